// File: rtl/fifo_async_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray/binary conversion and depth derivation.
package fifo_async_pkg;

  // Conversions work on a wide vector; narrower pointers are zero-extended,
  // which leaves their low bits converting exactly as at their native width.
  localparam int GRAY_MAX_W = 32;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/fifo_async_sync.sv
// Multi-flop synchroniser for a registered Gray pointer entering a new clock domain.
module fifo_async_sync #(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync_q [STAGES];
  logic [W-1:0] sync_d [STAGES];

  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '{default: '0};
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_async_lvl.sv
// Dual-clock FIFO with Gray-pointer crossing, per-side fill levels, threshold flags,
// sticky overflow/underflow and a registered or show-ahead read port.
module fifo_async_lvl
  import fifo_async_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 120,
  parameter int AE_THRESH   = 8,
  parameter int SHOWAHEAD   = 0
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              w_en,
  input  logic [DATA_W-1:0] wdata,
  output logic              wfull,
  output logic              walmost_full,
  output logic [ADDR_W:0]   wlevel,
  output logic              wovf,
  input  logic              r_en,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              rempty,
  output logic              ralmost_empty,
  output logic [ADDR_W:0]   rlevel,
  output logic              rudf
);

  localparam int DEPTH = fifo_depth(ADDR_W);
  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_THRESH);

  function automatic logic [PTR_W-1:0] to_gray(input logic [PTR_W-1:0] b);
    return PTR_W'(bin2gray(GRAY_MAX_W'(b)));
  endfunction

  function automatic logic [PTR_W-1:0] to_bin(input logic [PTR_W-1:0] g);
    return PTR_W'(gray2bin(GRAY_MAX_W'(g)));
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_rd;

  logic [PTR_W-1:0] wptr_bin_q, wptr_bin_d, wptr_gray_q, wptr_gray_d;
  logic [PTR_W-1:0] wlevel_q, wlevel_d, rgray_w;
  logic             wfull_q, wfull_d, walmost_full_q, walmost_full_d, wovf_q, wovf_d;
  logic             wr_accept;

  logic [PTR_W-1:0]  rptr_bin_q, rptr_bin_d, rptr_gray_q, rptr_gray_d;
  logic [PTR_W-1:0]  rlevel_q, rlevel_d, wgray_r;
  logic              rempty_q, rempty_d, ralmost_empty_q, ralmost_empty_d, rudf_q, rudf_d;
  logic              rvalid_q, rvalid_d, rd_accept;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  fifo_async_sync #(.W(PTR_W), .STAGES(SYNC_STAGES)) u_sync_r2w (
    .clk(wclk), .rst_n(wrst_n), .d(rptr_gray_q), .q(rgray_w)
  );

  fifo_async_sync #(.W(PTR_W), .STAGES(SYNC_STAGES)) u_sync_w2r (
    .clk(rclk), .rst_n(rrst_n), .d(wptr_gray_q), .q(wgray_r)
  );

  // Full compares the post-write pointer, so the flag rises with the DEPTH-th write.
  always_comb begin
    wr_accept      = w_en && !wfull_q;
    wptr_bin_d     = wptr_bin_q + PTR_W'(wr_accept);
    wptr_gray_d    = to_gray(wptr_bin_d);
    wfull_d        = (wptr_gray_d == {~rgray_w[PTR_W-1 -: 2], rgray_w[PTR_W-3:0]});
    wlevel_d       = wptr_bin_d - to_bin(rgray_w);
    walmost_full_d = (wlevel_d >= AF_LVL);
    wovf_d         = wovf_q | (w_en & wfull_q);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr_bin_q     <= '0;
      wptr_gray_q    <= '0;
      wfull_q        <= 1'b0;
      wlevel_q       <= '0;
      walmost_full_q <= 1'b0;
      wovf_q         <= 1'b0;
    end else begin
      wptr_bin_q     <= wptr_bin_d;
      wptr_gray_q    <= wptr_gray_d;
      wfull_q        <= wfull_d;
      wlevel_q       <= wlevel_d;
      walmost_full_q <= walmost_full_d;
      wovf_q         <= wovf_d;
    end
  end

  // NOTE: storage has no reset; only entries the pointers mark as written are ever read.
  always_ff @(posedge wclk) begin
    if (wr_accept) mem[wptr_bin_q[ADDR_W-1:0]] <= wdata;
  end

  assign mem_rd = mem[rptr_bin_q[ADDR_W-1:0]];

  always_comb begin
    rd_accept       = r_en && !rempty_q;
    rptr_bin_d      = rptr_bin_q + PTR_W'(rd_accept);
    rptr_gray_d     = to_gray(rptr_bin_d);
    rempty_d        = (rptr_gray_d == wgray_r);
    rlevel_d        = to_bin(wgray_r) - rptr_bin_d;
    ralmost_empty_d = (rlevel_d <= AE_LVL);
    rudf_d          = rudf_q | (r_en & rempty_q);
    rdata_d         = rdata_q;
    rvalid_d        = 1'b0;
    if (SHOWAHEAD == 0) begin
      rvalid_d = rd_accept;
      if (rd_accept) rdata_d = mem_rd;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rptr_bin_q      <= '0;
      rptr_gray_q     <= '0;
      rempty_q        <= 1'b1;
      rlevel_q        <= '0;
      ralmost_empty_q <= 1'b1;
      rudf_q          <= 1'b0;
      rvalid_q        <= 1'b0;
      rdata_q         <= '0;
    end else begin
      rptr_bin_q      <= rptr_bin_d;
      rptr_gray_q     <= rptr_gray_d;
      rempty_q        <= rempty_d;
      rlevel_q        <= rlevel_d;
      ralmost_empty_q <= ralmost_empty_d;
      rudf_q          <= rudf_d;
      rvalid_q        <= rvalid_d;
      rdata_q         <= rdata_d;
    end
  end

  assign wfull         = wfull_q;
  assign walmost_full  = walmost_full_q;
  assign wlevel        = wlevel_q;
  assign wovf          = wovf_q;
  assign rempty        = rempty_q;
  assign ralmost_empty = ralmost_empty_q;
  assign rlevel        = rlevel_q;
  assign rudf          = rudf_q;
  // Show-ahead presents the head word combinationally while the FIFO is non-empty.
  assign rdata  = (SHOWAHEAD != 0) ? (rempty_q ? '0 : mem_rd) : rdata_q;
  assign rvalid = (SHOWAHEAD != 0) ? !rempty_q : rvalid_q;

endmodule
